// File: rtl/qdr_arb2_if.sv
// qdr_arb2_if: one QDR user-port burst link (req/ack, 2-beat 72-bit bursts).
// The same bundle is used for each requesting master and for the link to
// the QDR controller.  The arbiter takes the slave view of each master and
// the master view of the controller.
interface qdr_arb2_if;
    logic        req;
    logic        ack;
    logic [31:0] addr;
    logic        r;
    logic        w;
    logic [71:0] d;
    logic [7:0]  be;
    logic [71:0] q;
    logic        qvld;

    // Requester side: issues bursts, sees acceptance and read data.
    modport master (output req, addr, r, w, d, be, input ack, q);
    // Responder side: accepts bursts, returns ack and tagged read data.
    modport slave  (input req, addr, r, w, d, be, output ack, q, qvld);
endinterface

// File: rtl/qdr_arb2.sv
// qdr_arb2: two-master arbiter in front of one QDR controller user port.
// Grants one 2-beat burst at a time, steers address/control/write beats
// from the owner, and routes read-data valid back to the owner through a
// latency-tag shift register.
// Build option: define QDR_ARB_FIXED_PRIO_EN for fixed priority (master 0
// wins every tie); left undefined the arbiter is round-robin.
module qdr_arb2 #(
    parameter int QDR_LATENCY = 10          // ack cycle to first read beat, 2..31
) (
    input  logic        qdr_clk,
    input  logic        qdr_rst_n,
    qdr_arb2_if.slave   m0,
    qdr_arb2_if.slave   m1,
    qdr_arb2_if.master  qdr
);
    localparam int DEPTH = QDR_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
`ifndef QDR_ARB_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif
    logic        grant;

    logic        own_req, own_r, own_w;
    logic [31:0] own_addr;
    logic [71:0] own_d;
    logic [7:0]  own_be;

    logic        req_c, r_c, w_c, ack0_c, ack1_c, push_c;
    logic [31:0] addr_c;
    logic [71:0] d_c;
    logic [7:0]  be_c;

    logic [DEPTH-1:0] tag_rd_q, tag_rd_d, tag_own_q, tag_own_d;

    // Owner's view of the request bundle
    assign own_req  = owner_q ? m1.req  : m0.req;
    assign own_r    = owner_q ? m1.r    : m0.r;
    assign own_w    = owner_q ? m1.w    : m0.w;
    assign own_addr = owner_q ? m1.addr : m0.addr;
    assign own_d    = owner_q ? m1.d    : m0.d;
    assign own_be   = owner_q ? m1.be   : m0.be;

    // Arbiter state, owner and round-robin history
    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
`ifndef QDR_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;            // so master 0 wins the first tie
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifndef QDR_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state, grant selection and controller-side steering
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifndef QDR_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        grant   = 1'b0;
        req_c   = 1'b0;
        r_c     = 1'b0;
        w_c     = 1'b0;
        addr_c  = '0;
        d_c     = '0;
        be_c    = '0;
        ack0_c  = 1'b0;
        ack1_c  = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0.req && m1.req) begin
`ifdef QDR_ARB_FIXED_PRIO_EN
                    grant = 1'b0;
`else
                    grant = ~last_q;
`endif
                end else begin
                    grant = m1.req;
                end
                if (m0.req || m1.req) begin
                    owner_d = grant;
`ifndef QDR_ARB_FIXED_PRIO_EN
                    last_d  = grant;
`endif
                    state_d = OWN;
                end
            end
            OWN: begin
                req_c  = own_req;
                addr_c = own_addr;
                d_c    = own_d;
                be_c   = own_be;
                r_c    = own_req & own_r;
                w_c    = own_req & own_w & ~own_r;   // read wins a r/w conflict
                if (!own_req) begin
                    state_d = IDLE;                  // owner withdrew: abort
                end else if (qdr.ack) begin
                    state_d = SECOND;
                    push_c  = 1'b1;
                    ack0_c  = ~owner_q;
                    ack1_c  = owner_q;
                end
            end
            SECOND: begin
                // second write beat still comes from the owner
                addr_c  = own_addr;
                d_c     = own_d;
                be_c    = own_be;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign qdr.req  = req_c;
    assign qdr.r    = r_c;
    assign qdr.w    = w_c;
    assign qdr.addr = addr_c;
    assign qdr.d    = d_c;
    assign qdr.be   = be_c;
    assign m0.ack   = ack0_c;
    assign m1.ack   = ack1_c;
    assign m0.q     = qdr.q;
    assign m1.q     = qdr.q;

    // Tag pipeline: stage 0 loads at the ack, each stage shifts one deeper
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_rd_d[gi]  = push_c & r_c;
                assign tag_own_d[gi] = owner_q;
            end else begin : g_body
                assign tag_rd_d[gi]  = tag_rd_q[gi-1];
                assign tag_own_d[gi] = tag_own_q[gi-1];
            end
        end
    endgenerate

    // Shift register of {read, owner} tags; cleared by reset to drop in-flight reads
    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            tag_rd_q  <= '0;
            tag_own_q <= '0;
        end else begin
            tag_rd_q  <= tag_rd_d;
            tag_own_q <= tag_own_d;
        end
    end

    // Beat 0 sits in stage LATENCY-1, beat 1 in the last stage
    assign m0.qvld = (tag_rd_q[QDR_LATENCY-1] & ~tag_own_q[QDR_LATENCY-1]) |
                     (tag_rd_q[QDR_LATENCY]   & ~tag_own_q[QDR_LATENCY]);
    assign m1.qvld = (tag_rd_q[QDR_LATENCY-1] &  tag_own_q[QDR_LATENCY-1]) |
                     (tag_rd_q[QDR_LATENCY]   &  tag_own_q[QDR_LATENCY]);
endmodule
